// File: rtl/bca_pkg.sv
// Shared types for the bit-count engine.
// States and per-operand analysis modes.
package bca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ONES,
    ZEROS,
    TZ,
    LZ
  } mode_e;

endpackage

// File: rtl/bit_count_engine_if.sv
// Operand and result handshakes for the bit-count engine.
// master = producer/consumer side, slave = engine side.
interface bit_count_engine_if #(
  parameter int WIDTH = 8
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             busy;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_count,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_count,
    output busy
  );

endinterface

// File: rtl/bca_chunk_eval.sv
// Combinational analysis of one B-bit chunk:
// population count, trailing zeros and nonzero flag.
module bca_chunk_eval #(
  parameter int B  = 1,
  parameter int CW = 4
) (
  input  logic [B-1:0]  chunk_i,
  output logic [CW-1:0] pop_o,
  output logic [CW-1:0] tz_o,
  output logic          nz_o
);

  logic found;

  // Popcount and lowest set bit index (tz valid only when nonzero)
  always_comb begin
    pop_o = '0;
    tz_o  = '0;
    found = 1'b0;
    for (int i = 0; i < B; i++) begin
      pop_o = pop_o + CW'(chunk_i[i]);
      if (!found && chunk_i[i]) begin
        tz_o  = CW'(i);
        found = 1'b1;
      end
    end
  end

  assign nz_o = |chunk_i;

endmodule

// File: rtl/bit_count_engine.sv
// Serial bit-analysis engine: ones/zeros count, trailing or
// leading zeros of a WIDTH-bit operand, B bits per cycle.
module bit_count_engine
  import bca_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CW             = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                reset,
  bit_count_engine_if.slave  bus
);

  localparam int B = BITS_PER_CYCLE;

  if (WIDTH < 2) begin : g_width_chk
    $error("bit_count_engine: WIDTH must be >= 2");
  end
  if (B < 1 || (WIDTH % B) != 0) begin : g_bpc_chk
    $error("bit_count_engine: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] rev_data;
  logic [B-1:0]     chunk;
  logic [CW-1:0]    chunk_pop;
  logic [CW-1:0]    chunk_tz;
  logic             chunk_nz;
  logic             cnt_mode;

  assign chunk    = sreg_q[B-1:0];
  assign cnt_mode = (mode_q == ONES) || (mode_q == ZEROS);

  bca_chunk_eval #(
    .B  (B),
    .CW (CW)
  ) u_eval (
    .chunk_i (chunk),
    .pop_o   (chunk_pop),
    .tz_o    (chunk_tz),
    .nz_o    (chunk_nz)
  );

  // Load-time transform: zeros become ones, LZ becomes TZ of the reversal
  always_comb begin
    rev_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_data[i] = bus.in_data[WIDTH-1-i];
    end
    case (mode_e'(bus.in_mode))
      ZEROS:   load_val = ~bus.in_data;
      LZ:      load_val = rev_data;
      default: load_val = bus.in_data;
    endcase
  end

  // Next-state, shift register and count update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_d  = load_val;
          count_d = '0;
          mode_d  = mode_e'(bus.in_mode);
          state_d = RUN;
        end
      end
      RUN: begin
        if (sreg_q == '0) begin
          state_d = DONE;
          if (!cnt_mode) begin
            count_d = CW'(WIDTH);
          end
        end else if (cnt_mode) begin
          count_d = count_q + chunk_pop;
          sreg_d  = sreg_q >> B;
        end else if (chunk_nz) begin
          count_d = count_q + chunk_tz;
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(B);
          sreg_d  = sreg_q >> B;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= ONES;
      sreg_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_count = (state_q == DONE) ? count_q : '0;

endmodule
